dense_layer_controller: RTL
===========================

# dense_layer_controller

Sequencer for a time-multiplexed dense layer. One shared multiply-accumulate datapath (weight memory, accumulator, bias adder, activation unit) is stepped neuron by neuron and input by input. The controller owns the `inputs_ready`/`outputs_ready` handshake used between layers of `neural_network`. It drives only indices and strobes; all fixed-point arithmetic lives in the datapath.

## Interface
- `NUM_INPUTS`, default 120: inputs per neuron, i.e. the previous layer's SIZE, ≥1.
- `NUM_NEURONS`, default 84: neurons in this layer, ≥1.
- `MAC_LATENCY`, default 1: datapath cycles from an `accumulate` strobe until its product is in the accumulator, ≥0.
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low. Low immediately forces every output to its reset value and the FSM to IDLE.
- `inputs_ready`, in, 1: previous layer's outputs are valid; level, start request.
- `outputs_ready`, out, 1: this layer's outputs are valid; level. Reset 0.
- `busy`, out, 1: high in every state except IDLE and DONE. Reset 0.
- `input_index`, out, $clog2(NUM_INPUTS) (min 1): input selected for the MAC. Reset 0.
- `neuron_index`, out, $clog2(NUM_NEURONS) (min 1): neuron being computed. Reset 0.
- `weight_address`, out, $clog2(NUM_INPUTS*NUM_NEURONS) (min 1): equals neuron_index*NUM_INPUTS + input_index. Reset 0.
- `clear_accumulator`, `accumulate`, `add_bias`, `activate`, `write_output`, out, 1 each: one-cycle datapath strobes. Reset 0.

## Operation
- States: IDLE, CLEAR, MAC, DRAIN, BIAS, ACTIVATE, WRITE, DONE. Registered Moore outputs.
- IDLE → CLEAR when `inputs_ready`=1. This is start acceptance: clear `outputs_ready`, zero both indices.
- CLEAR: `clear_accumulator`=1 for 1 cycle → MAC.
- MAC: `accumulate`=1 for NUM_INPUTS cycles. `input_index` steps 0..NUM_INPUTS-1, one per cycle, with `weight_address` valid in the same cycle. After the last input: `input_index` wraps to 0 and the FSM goes to DRAIN, or to BIAS when MAC_LATENCY=0.
- DRAIN: exactly MAC_LATENCY cycles, no strobes → BIAS.
- BIAS: `add_bias`=1, 1 cycle → ACTIVATE.
- ACTIVATE: `activate`=1, 1 cycle → WRITE. The activation type (NONE/RELU/SIGMOID) is the datapath's concern.
- WRITE: `write_output`=1 at the current `neuron_index`, 1 cycle. If this is not the last neuron: increment `neuron_index` → CLEAR. If it is the last neuron: `neuron_index` wraps to 0, set `outputs_ready` → DONE.
- DONE: `outputs_ready`=1. Stay while `inputs_ready`=1; → IDLE when `inputs_ready`=0. `outputs_ready` stays 1 in IDLE until the next start acceptance.
- Once started, the run ignores `inputs_ready` dropping and always completes.
- Index counters compare against NUM-1, so non-power-of-two sizes wrap correctly. `weight_address` never exceeds NUM_INPUTS*NUM_NEURONS-1.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No partial `write_output` is issued afterwards.

## Timing
- Per-neuron cycles P = NUM_INPUTS + MAC_LATENCY + 4.
- Start accepted at edge 0. `outputs_ready` rises at edge NUM_NEURONS*P.
- Strobes are never simultaneous. Exactly one state is active per cycle.
- A re-start needs `inputs_ready` low for ≥1 cycle in DONE. A held-high `inputs_ready` does not re-run the layer.

## Structure
- Shared package (`include.svh`): `controller_state` enum typedef. The existing layer_builder/fixed-point definitions are reused unchanged. No new numeric constants.
- One sub-module, `wrap_counter` (parameter MAX, ports `clock`/`reset`/`clear`/`enable`, outputs `count` and `last`), instantiated for `input_index` and `neuron_index`.
- `weight_address` is registered and computed incrementally (+1 per accumulate, no multiplier).

## Test plan
- NUM_INPUTS=3, NUM_NEURONS=2, MAC_LATENCY=1. Pulse `inputs_ready` high at edge 0 → `outputs_ready` rises at edge 16. `weight_address` sequence 0,1,2,3,4,5. `write_output` seen exactly twice, with neuron_index 0 then 1.
- Same config, MAC_LATENCY=0 → no DRAIN cycle, `outputs_ready` at edge 14. `accumulate` high 6 cycles total.
- NUM_INPUTS=5, NUM_NEURONS=3 (non-power-of-two) → `input_index` wraps 4→0 and `weight_address` ends at 14. Never 15.
- Hold `inputs_ready` high through completion → FSM stays in DONE, no second run. Drop it, then raise it again → `outputs_ready` clears at acceptance and the second run matches the first cycle-for-cycle.
- Drop `inputs_ready` mid-MAC → run completes unchanged.
- Assert `reset` low asynchronously during ACTIVATE of neuron 1 → all outputs 0 before the next edge, no `write_output`. Release and restart → full correct run.

Source files
------------

// File: rtl/dense_layer_controller_pkg.sv
// Shared definitions for the dense layer sequencer.
// Holds the controller state encoding and the index-width helper used to
// size every index/address port (minimum width of one bit).
package dense_layer_controller_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    MAC      = 3'd2,
    DRAIN    = 3'd3,
    BIAS     = 3'd4,
    ACTIVATE = 3'd5,
    WRITE    = 3'd6,
    DONE     = 3'd7
  } controller_state;

  // Bits needed to hold 0..n-1; never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_layer_controller_wrap_counter.sv
// Modulo-MAX up-counter used for the input and neuron indices.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset, count returns to 0
//   clear  - synchronous return to 0 (takes priority over enable)
//   enable - advance by one, wrapping from MAX-1 to 0
//   count  - registered count value
//   last   - count currently equals MAX-1
module wrap_counter
  import dense_layer_controller_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      enable,
  output logic [idx_width(MAX)-1:0] count,
  output logic                      last
);

  localparam int              W        = idx_width(MAX);
  localparam logic [W-1:0]    LAST_VAL = W'(MAX - 1);

  logic [W-1:0] count_q;

  // Count register: compare against MAX-1 so non-power-of-two sizes wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= {W{1'b0}};
    end else if (clear) begin
      count_q <= {W{1'b0}};
    end else if (enable) begin
      count_q <= (count_q == LAST_VAL) ? {W{1'b0}} : count_q + W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign count = count_q;
  assign last  = (count_q == LAST_VAL);

endmodule

// File: rtl/dense_layer_controller.sv
// Sequencer for a time-multiplexed dense layer. Steps one shared MAC
// datapath neuron by neuron and input by input, issuing indices and
// one-cycle strobes; owns the inputs_ready/outputs_ready layer handshake.
// Ports:
//   clock, reset          - rising-edge clock, async active-low reset
//   inputs_ready          - previous layer valid (level start request)
//   outputs_ready         - this layer's outputs valid (level)
//   busy                  - high outside IDLE and DONE
//   input_index           - input selected for the MAC
//   neuron_index          - neuron being computed
//   weight_address        - neuron_index*NUM_INPUTS + input_index
//   clear_accumulator, accumulate, add_bias, activate, write_output
//                         - mutually exclusive one-cycle datapath strobes
// All outputs are registered from the next state (Moore, no comb paths).
module dense_layer_controller
  import dense_layer_controller_pkg::*;
#(
  parameter int NUM_INPUTS  = 120,
  parameter int NUM_NEURONS = 84,
  parameter int MAC_LATENCY = 1
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           inputs_ready,
  output logic                                           outputs_ready,
  output logic                                           busy,
  output logic [idx_width(NUM_INPUTS)-1:0]               input_index,
  output logic [idx_width(NUM_NEURONS)-1:0]              neuron_index,
  output logic [idx_width(NUM_INPUTS*NUM_NEURONS)-1:0]   weight_address,
  output logic                                           clear_accumulator,
  output logic                                           accumulate,
  output logic                                           add_bias,
  output logic                                           activate,
  output logic                                           write_output
);

  localparam int            AW         = idx_width(NUM_INPUTS * NUM_NEURONS);
  localparam int            DW         = idx_width(MAC_LATENCY + 1);
  localparam logic [AW-1:0] ROW_STEP   = AW'(NUM_INPUTS);
  localparam logic [AW-1:0] ROW_REWIND = AW'(NUM_INPUTS - 1);

  controller_state state_q, state_d;
  logic            start_s, mac_s, write_s;
  logic            in_last_s, neu_last_s, drain_done_s;
  logic [DW-1:0]   drain_cnt_q;
  logic [AW-1:0]   addr_q;
  logic            outputs_ready_q, busy_q;
  logic            clear_q, accumulate_q, add_bias_q, activate_q, write_q;

  assign start_s      = (state_q == IDLE) && inputs_ready;
  assign mac_s        = (state_q == MAC);
  assign write_s      = (state_q == WRITE);
  assign drain_done_s = ((int'(drain_cnt_q) + 1) >= MAC_LATENCY);

  wrap_counter #(.MAX(NUM_INPUTS)) u_input_ctr (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_s),
    .enable (mac_s),
    .count  (input_index),
    .last   (in_last_s)
  );

  wrap_counter #(.MAX(NUM_NEURONS)) u_neuron_ctr (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_s),
    .enable (write_s),
    .count  (neuron_index),
    .last   (neu_last_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; inputs_ready is only looked at in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (inputs_ready) state_d = CLEAR; else state_d = IDLE;
      CLEAR:    state_d = MAC;
      MAC: begin
        if (!in_last_s)            state_d = MAC;
        else if (MAC_LATENCY == 0) state_d = BIAS;
        else                       state_d = DRAIN;
      end
      DRAIN:    if (drain_done_s) state_d = BIAS; else state_d = DRAIN;
      BIAS:     state_d = ACTIVATE;
      ACTIVATE: state_d = WRITE;
      WRITE:    if (neu_last_s) state_d = DONE; else state_d = CLEAR;
      DONE:     if (inputs_ready) state_d = DONE; else state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Drain timer: counts cycles spent in DRAIN, zero everywhere else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drain_cnt_q <= {DW{1'b0}};
    end else if ((state_q == DRAIN) && !drain_done_s) begin
      drain_cnt_q <= drain_cnt_q + DW'(1);
    end else begin
      drain_cnt_q <= {DW{1'b0}};
    end
  end

  // Weight address tracks neuron*NUM_INPUTS + input without a multiplier:
  // +1 per accumulate, rewind to the row base when the input index wraps,
  // then +NUM_INPUTS when the neuron index advances.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q <= {AW{1'b0}};
    end else if (start_s) begin
      addr_q <= {AW{1'b0}};
    end else if (mac_s) begin
      addr_q <= in_last_s ? (addr_q - ROW_REWIND) : (addr_q + AW'(1));
    end else if (write_s) begin
      addr_q <= neu_last_s ? {AW{1'b0}} : (addr_q + ROW_STEP);
    end else begin
      addr_q <= addr_q;
    end
  end

  // Registered Moore outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outputs_ready_q <= 1'b0;
      busy_q          <= 1'b0;
      clear_q         <= 1'b0;
      accumulate_q    <= 1'b0;
      add_bias_q      <= 1'b0;
      activate_q      <= 1'b0;
      write_q         <= 1'b0;
    end else begin
      // outputs_ready persists through IDLE until the next start.
      if (start_s) begin
        outputs_ready_q <= 1'b0;
      end else if (state_d == DONE) begin
        outputs_ready_q <= 1'b1;
      end else begin
        outputs_ready_q <= outputs_ready_q;
      end
      busy_q       <= (state_d != IDLE) && (state_d != DONE);
      clear_q      <= (state_d == CLEAR);
      accumulate_q <= (state_d == MAC);
      add_bias_q   <= (state_d == BIAS);
      activate_q   <= (state_d == ACTIVATE);
      write_q      <= (state_d == WRITE);
    end
  end

  assign outputs_ready     = outputs_ready_q;
  assign busy              = busy_q;
  assign weight_address    = addr_q;
  assign clear_accumulator = clear_q;
  assign accumulate        = accumulate_q;
  assign add_bias          = add_bias_q;
  assign activate          = activate_q;
  assign write_output      = write_q;

endmodule
